// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the enc8to10 packet front end.
package enc_pkg;

    localparam logic [7:0] K281 = 8'h3C;
    localparam logic [7:0] K285 = 8'hBC;
    localparam logic [7:0] K237 = 8'hF7;

    localparam int CRC_GAP_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DRAIN,
        S_EOP,
        S_GAP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting index at or above i_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_any
);
    localparam int IW = $clog2(NREQ);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[wrap_add(i_ptr, i)]) begin
                o_any = 1'b1;
                o_idx = wrap_add(i_ptr, i);
            end
        end
    end

    assign o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/enc_pkt_sched.sv
// Round-robin packet scheduler that frames byte streams for enc8to10:
// 4x K28.1 preamble, payload, K28.5 terminator, then a CRC hold-off gap.
module enc_pkt_sched
    import enc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = 64,
    parameter int CRC_GAP = CRC_GAP_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    pushin,
    output logic [8:0]              datain,
    output logic                    startin,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_bc,
    output logic                    err_len
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int GW = $clog2(CRC_GAP + 1);

    sched_state_t  r_state, w_state_n;
    logic [IW-1:0] r_grant, r_ptr;
    logic [NREQ-1:0] r_gnt_oh;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [1:0]    r_pre, w_pre_n;
    logic [GW-1:0] r_gap, w_gap_n;
    logic          r_term, w_term_n;
    logic          r_push, w_push_n, r_start, w_start_n;
    logic          r_ebc, w_ebc_n, r_elen, w_elen_n;
    logic [8:0]    r_data, w_data_n;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any, w_acc, w_last, w_load;
    logic [7:0]      w_byte;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign req_ready = (r_state == S_DATA || r_state == S_DRAIN) ? r_gnt_oh : '0;
    assign w_acc     = |(req_valid & req_ready);
    assign w_byte    = req_data[{r_grant, 3'b000} +: 8];
    assign w_last    = req_last[r_grant];

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_pre_n   = r_pre;
        w_gap_n   = r_gap;
        w_term_n  = r_term;
        w_push_n  = 1'b0;
        w_data_n  = '0;
        w_start_n = 1'b0;
        w_ebc_n   = 1'b0;
        w_elen_n  = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_load    = 1'b1;
                w_cnt_n   = '0;
                w_pre_n   = '0;
                w_term_n  = 1'b0;
                w_state_n = S_PRE;
            end
            S_PRE: begin
                w_push_n  = 1'b1;
                w_data_n  = {1'b1, K281};
                w_start_n = (r_pre == 2'd0);
                w_pre_n   = r_pre + 2'd1;
                if (r_pre == 2'd3) w_state_n = S_DATA;
            end
            S_DATA: if (w_acc) begin
                w_cnt_n  = r_cnt + CW'(1);
                w_push_n = 1'b1;
                // A payload 0xBC would be taken as K28.5, so it becomes the terminator.
                if (w_byte == K285) begin
                    w_data_n  = {1'b1, K285};
                    w_ebc_n   = 1'b1;
                    w_term_n  = 1'b1;
                    w_state_n = w_last ? S_GAP : S_DRAIN;
                end else begin
                    w_data_n = {1'b0, w_byte};
                    if (w_last) begin
                        w_state_n = S_EOP;
                    end else if (w_cnt_n == CW'(MAX_LEN)) begin
                        w_elen_n  = 1'b1;
                        w_state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!r_term) begin
                    w_push_n = 1'b1;
                    w_data_n = {1'b1, K285};
                    w_term_n = 1'b1;
                end
                if (w_acc && w_last) w_state_n = S_GAP;
            end
            S_EOP: begin
                w_push_n  = 1'b1;
                w_data_n  = {1'b1, K285};
                w_state_n = S_GAP;
            end
            S_GAP: begin
                // One extra state cycle: the terminator is still in the output register on entry.
                if (r_gap == GW'(CRC_GAP)) begin
                    w_gap_n   = '0;
                    w_state_n = S_IDLE;
                end else begin
                    w_gap_n = r_gap + GW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_gnt_oh <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_gap    <= '0;
            r_term   <= 1'b0;
            r_push   <= 1'b0;
            r_data   <= '0;
            r_start  <= 1'b0;
            r_ebc    <= 1'b0;
            r_elen   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_pre   <= w_pre_n;
            r_gap   <= w_gap_n;
            r_term  <= w_term_n;
            r_push  <= w_push_n;
            r_data  <= w_data_n;
            r_start <= w_start_n;
            r_ebc   <= w_ebc_n;
            r_elen  <= w_elen_n;
            if (w_load) begin
                r_grant  <= w_idx;
                r_gnt_oh <= w_gnt;
                r_ptr    <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
            end
        end
    end

    assign pushin   = r_push;
    assign datain   = r_data;
    assign startin  = r_start;
    assign err_bc   = r_ebc;
    assign err_len  = r_elen;
    assign grant_id = r_grant;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_enc_pkt_sched.sv
// Scoreboard bench for enc_pkt_sched: directed packets push expected encoder words,
// a negedge monitor pops and compares whenever pushin is high.
module tb_enc_pkt_sched;
    localparam int NREQ = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid, req_last, req_ready;
    logic [8*NREQ-1:0]     req_data;
    logic                  pushin, startin, busy, err_bc, err_len;
    logic [8:0]            datain;
    logic [1:0]            grant_id;

    logic                  tb_valid [NREQ];
    logic [7:0]            tb_data  [NREQ];
    logic                  tb_last  [NREQ];

    typedef struct {
        logic [8:0] data;
        logic       start;
        logic       ebc;
        logic       elen;
        int         gap;
        int         gid;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0, errors = 0;
    int   zeros = 0, idle_run = -1;
    logic prev_busy = 1'b0;

    enc_pkt_sched #(.NREQ(NREQ), .MAX_LEN(4), .CRC_GAP(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .pushin(pushin), .datain(datain), .startin(startin), .grant_id(grant_id),
        .busy(busy), .err_bc(err_bc), .err_len(err_len)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = tb_valid[i];
            req_data[8*i +: 8]   = tb_data[i];
            req_last[i]          = tb_last[i];
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void ex(input logic [8:0] d, input logic s, input logic eb, input logic el,
                               input int gap, input int gid);
        exp_t t;
        t.data = d; t.start = s; t.ebc = eb; t.elen = el; t.gap = gap; t.gid = gid;
        exp_q.push_back(t);
    endfunction

    function automatic void ex_pre(input int gid);
        ex(9'h13C, 1'b1, 1'b0, 1'b0, -1, gid);
        for (int k = 0; k < 3; k++) ex(9'h13C, 1'b0, 1'b0, 1'b0, 0, -1);
    endfunction

    function automatic void ex_one(input int gid, input logic [7:0] b);
        ex_pre(gid);
        ex({1'b0, b}, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h1BC, 1'b0, 1'b0, 1'b0, 0, -1);
    endfunction

    // Monitor: compare every pushed word against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            zeros     = 0;
            prev_busy = 1'b0;
        end else begin
            if (!busy && prev_busy) idle_run = zeros;
            prev_busy = busy;
            if (pushin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push: got %0h expected no output at %0t", datain, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("datain",  32'(datain),  32'(e.data));
                    chk("startin", 32'(startin), 32'(e.start));
                    chk("err_bc",  32'(err_bc),  32'(e.ebc));
                    chk("err_len", 32'(err_len), 32'(e.elen));
                    if (e.gap >= 0) chk("push_gap", 32'(zeros), 32'(e.gap));
                    if (e.gid >= 0) chk("grant_id", 32'(grant_id), 32'(e.gid));
                end
                zeros = 0;
            end else begin
                chk("idle_flags", 32'({startin, err_bc, err_len}), 32'd0);
                zeros++;
            end
        end
    end

    task automatic send(input int id, input logic [63:0] bytes, input int n,
                        input bit bubble, input bit has_last);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard        = 0;
            tb_valid[id] = 1'b1;
            tb_data[id]  = bytes[8*k +: 8];
            tb_last[id]  = has_last && (k == n - 1);
            while (!req_ready[id] && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 400) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: req%0d byte %0d got no ready expected ready", id, k);
                tb_valid[id] = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            tb_valid[id] = 1'b0;
            tb_last[id]  = 1'b0;
            if (bubble && k < n - 1) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy got 1 expected 0");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            tb_valid[i] = 1'b0;
            tb_data[i]  = 8'h00;
            tb_last[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({pushin, datain, startin, busy, err_bc, err_len, grant_id, req_ready}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'({busy, req_ready}), 32'd0);

        // Round robin: req0/req2 continuously valid, grants 0,2,0,2 (pointer wraps 3->0).
        ex_one(0, 8'hA0);
        ex_one(2, 8'hA2);
        ex_one(0, 8'hB0);
        ex_one(2, 8'hB2);
        fork
            begin send(0, 64'hA0, 1, 1'b0, 1'b1); send(0, 64'hB0, 1, 1'b0, 1'b1); end
            begin send(2, 64'hA2, 1, 1'b0, 1'b1); send(2, 64'hB2, 1, 1'b0, 1'b1); end
        join
        wait_idle();

        // Single packet from req1, then exactly 5 idle output cycles before busy drops.
        ex_pre(1);
        ex(9'h011, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h022, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h033, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h1BC, 1'b0, 1'b0, 1'b0, 0, -1);
        send(1, 64'h33_22_11, 3, 1'b0, 1'b1);
        wait_idle();
        @(negedge clk);
        chk("gap_len", 32'(idle_run), 32'd5);

        // Bubbles from req3; 4th byte hits MAX_LEN together with last -> normal EOP.
        ex_pre(3);
        ex(9'h031, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h032, 1'b0, 1'b0, 1'b0, 1, -1);
        ex(9'h033, 1'b0, 1'b0, 1'b0, 1, -1);
        ex(9'h034, 1'b0, 1'b0, 1'b0, 1, -1);
        ex(9'h1BC, 1'b0, 1'b0, 1'b0, 0, -1);
        send(3, 64'h34_33_32_31, 4, 1'b1, 1'b1);
        wait_idle();

        // 0xBC intercept from req0: 66 and 77 are drained silently.
        ex_pre(0);
        ex(9'h055, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h1BC, 1'b0, 1'b1, 1'b0, 0, -1);
        send(0, 64'h77_66_BC_55, 4, 1'b0, 1'b1);
        wait_idle();

        // Length limit (MAX_LEN=4) from req1: 4 forwarded, err_len, terminator, 2 drained.
        ex_pre(1);
        ex(9'h041, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h042, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h043, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h044, 1'b0, 1'b0, 1'b1, 0, -1);
        ex(9'h1BC, 1'b0, 1'b0, 1'b0, 0, -1);
        send(1, 64'h46_45_44_43_42_41, 6, 1'b0, 1'b1);
        wait_idle();

        // Reset mid-DATA from req2 after two payload bytes.
        ex_pre(2);
        ex(9'h051, 1'b0, 1'b0, 1'b0, 0, -1);
        ex(9'h052, 1'b0, 1'b0, 1'b0, 0, -1);
        send(2, 64'h52_51, 2, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midpkt_reset_outs", 32'({pushin, datain, startin, busy, err_bc, err_len, grant_id, req_ready}), 32'd0);
        chk("queue_before_reset", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Pointer must restart at 0: req1 beats req3.
        ex_one(1, 8'h61);
        ex_one(3, 8'h63);
        fork
            send(1, 64'h61, 1, 1'b0, 1'b1);
            send(3, 64'h63, 1, 1'b0, 1'b1);
        join
        wait_idle();
        repeat (5) @(negedge clk);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
